// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings for the multi-cycle hazard/forwarding controller.
package hazard_unit_mc_pkg;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // mul/div sequencer state
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_unit_mc_md_timer.sv
// Mul/div occupancy tracker: counts the busy window after an issue, frozen on memory wait.
module hazard_unit_mc_md_timer
  import hazard_unit_mc_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic freeze,
  output logic md_busy,
  output logic md_done
);

  // The issue cycle itself is not stalled, so the busy window is MD_LAT-1
  // cycles; cnt holds the number of busy cycles still to come after this one.
  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Next-state: load on issue, count down per unfrozen busy cycle, leave on zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      case (state_q)
        MD_IDLE: if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CW'(MD_LAT - 2);
        end
        MD_BUSY: if (cnt_q == '0) state_d = MD_IDLE;
                 else             cnt_d   = cnt_q - CW'(1);
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // State and counter registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_busy = (state_q == MD_BUSY);
  assign md_done = (state_q == MD_BUSY) && (cnt_q == '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller with mul/div stall, dmem wait, timeout flag and stall statistics.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int MEM_TO = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic [REG_AW-1:0] rs_ex,
  input  logic [REG_AW-1:0] rt_ex,
  input  logic [REG_AW-1:0] wreg_ex,
  input  logic [REG_AW-1:0] wreg_mem,
  input  logic [REG_AW-1:0] wreg_wb,
  input  logic              regwrite_ex,
  input  logic              regwrite_mem,
  input  logic              regwrite_wb,
  input  logic              memtoreg_ex,
  input  logic              memtoreg_mem,
  input  logic              branch_id,
  input  logic              md_start_ex,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              clr_stats,
  output logic [1:0]        fwd_a_ex,
  output logic [1:0]        fwd_b_ex,
  output logic              fwd_a_id,
  output logic              fwd_b_id,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_ex,
  output logic              flush_mem,
  output logic              flush_wb,
  output logic              md_busy,
  output logic              md_done,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int WAIT_W = $clog2(MEM_TO + 1);

  function automatic logic match(input logic [REG_AW-1:0] x, r, input logic w);
    return w && (r != '0) && (r == x);
  endfunction

  logic memwait, lwstall, brstall;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;

  assign memwait = dmem_req && !dmem_ready;

  hazard_unit_mc_md_timer #(.MD_LAT(MD_LAT)) u_md (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start_ex),
    .freeze  (memwait),
    .md_busy (md_busy),
    .md_done (md_done)
  );

  // Operand forwarding: MEM result is younger than WB, so it wins.
  always_comb begin
    fwd_a_ex = FWD_RF;
    fwd_b_ex = FWD_RF;
    if (match(rs_ex, wreg_mem, regwrite_mem))     fwd_a_ex = FWD_MEM;
    else if (match(rs_ex, wreg_wb, regwrite_wb))  fwd_a_ex = FWD_WB;
    if (match(rt_ex, wreg_mem, regwrite_mem))     fwd_b_ex = FWD_MEM;
    else if (match(rt_ex, wreg_wb, regwrite_wb))  fwd_b_ex = FWD_WB;
    fwd_a_id = match(rs_id, wreg_mem, regwrite_mem);
    fwd_b_id = match(rt_id, wreg_mem, regwrite_mem);
  end

  // Stall/flush arbitration: memory wait freezes everything, mul/div holds up to EX,
  // load-use and branch hazards only hold the front end.
  always_comb begin
    lwstall = memtoreg_ex && (wreg_ex != '0) && ((wreg_ex == rs_id) || (wreg_ex == rt_id));
    brstall = branch_id &&
              (match(rs_id, wreg_ex, regwrite_ex) || match(rt_id, wreg_ex, regwrite_ex) ||
               (memtoreg_mem && (match(rs_id, wreg_mem, regwrite_mem) ||
                                 match(rt_id, wreg_mem, regwrite_mem))));
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    if (memwait) begin
      {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = '1;
    end else if (md_busy) begin
      {stall_if, stall_id, stall_ex, flush_mem} = '1;
    end else if (lwstall || brstall) begin
      {stall_if, stall_id, flush_ex} = '1;
    end
  end

  // Wait length, sticky timeout and saturating stall counter; clear beats update.
  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    scnt_d    = scnt_q;
    if (memwait) begin
      wait_d = (wait_q == WAIT_W'(MEM_TO)) ? wait_q : wait_q + WAIT_W'(1);
      if (wait_q >= WAIT_W'(MEM_TO - 1)) timeout_d = 1'b1;
    end
    if (stall_if && (scnt_q != '1)) scnt_d = scnt_q + CNT_W'(1);
    if (clr_stats) begin
      timeout_d = 1'b0;
      scnt_d    = '0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
      scnt_q    <= '0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      scnt_q    <= scnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = scnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Randomized + directed bench for hazard_unit_mc against a behavioural model.
module tb_hazard_unit_mc;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int MEM_TO = 16;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic [REG_AW-1:0] rs_id, rt_id, rs_ex, rt_ex, wreg_ex, wreg_mem, wreg_wb;
  logic regwrite_ex, regwrite_mem, regwrite_wb, memtoreg_ex, memtoreg_mem;
  logic branch_id, md_start_ex, dmem_req, dmem_ready, clr_stats;
  logic [1:0] fwd_a_ex, fwd_b_ex;
  logic fwd_a_id, fwd_b_id, stall_if, stall_id, stall_ex, stall_mem;
  logic flush_ex, flush_mem, flush_wb, md_busy, md_done, mem_timeout;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .MEM_TO(MEM_TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .wreg_ex(wreg_ex), .wreg_mem(wreg_mem), .wreg_wb(wreg_wb),
    .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
    .memtoreg_ex(memtoreg_ex), .memtoreg_mem(memtoreg_mem), .branch_id(branch_id),
    .md_start_ex(md_start_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .clr_stats(clr_stats),
    .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .md_busy(md_busy), .md_done(md_done), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_rem;   // busy cycles still owed by the mul/div unit
  int m_wait;  // consecutive memory-wait cycles so far
  bit m_to;
  int m_cnt;

  function automatic bit mt(input int x, input int r, input bit w);
    return w && r != 0 && r == x;
  endfunction

  always @(negedge clk) begin
    bit mw, lw, br, busy;
    bit e_sif, e_sid, e_sex, e_smem, e_fex, e_fmem, e_fwb;
    int ea, eb;
    if (!reset_n) begin
      m_rem = 0; m_wait = 0; m_to = 0; m_cnt = 0;
    end
    mw   = dmem_req && !dmem_ready;
    busy = m_rem > 0;
    lw   = memtoreg_ex && wreg_ex != 0 && (wreg_ex == rs_id || wreg_ex == rt_id);
    br   = branch_id && (mt(rs_id, wreg_ex, regwrite_ex) || mt(rt_id, wreg_ex, regwrite_ex) ||
           (memtoreg_mem && (mt(rs_id, wreg_mem, regwrite_mem) || mt(rt_id, wreg_mem, regwrite_mem))));
    ea = mt(rs_ex, wreg_mem, regwrite_mem) ? 2 : mt(rs_ex, wreg_wb, regwrite_wb) ? 1 : 0;
    eb = mt(rt_ex, wreg_mem, regwrite_mem) ? 2 : mt(rt_ex, wreg_wb, regwrite_wb) ? 1 : 0;
    e_smem = mw; e_fwb = mw;
    e_fmem = !mw && busy;
    e_sex  = mw || busy;
    e_fex  = !mw && !busy && (lw || br);
    e_sif  = mw || busy || lw || br;
    e_sid  = e_sif;
    chk("fwd_a_ex", fwd_a_ex, ea);
    chk("fwd_b_ex", fwd_b_ex, eb);
    chk("fwd_a_id", fwd_a_id, mt(rs_id, wreg_mem, regwrite_mem));
    chk("fwd_b_id", fwd_b_id, mt(rt_id, wreg_mem, regwrite_mem));
    chk("stalls", {stall_if, stall_id, stall_ex, stall_mem}, {e_sif, e_sid, e_sex, e_smem});
    chk("flushes", {flush_ex, flush_mem, flush_wb}, {e_fex, e_fmem, e_fwb});
    chk("md_busy", md_busy, busy);
    chk("md_done", md_done, m_rem == 1);
    chk("mem_timeout", mem_timeout, m_to);
    chk("stall_count", stall_count, m_cnt);
    // advance model to the state after the coming rising edge
    if (reset_n) begin
      if (m_rem > 0) begin
        if (!mw) m_rem--;
      end else if (md_start_ex && !mw) m_rem = MD_LAT - 1;
      if (mw) begin
        m_wait++;
        if (m_wait >= MEM_TO) m_to = 1;
      end else m_wait = 0;
      if (e_sif && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (clr_stats) begin m_to = 0; m_cnt = 0; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; wreg_ex = 0; wreg_mem = 0; wreg_wb = 0;
    regwrite_ex = 0; regwrite_mem = 0; regwrite_wb = 0; memtoreg_ex = 0; memtoreg_mem = 0;
    branch_id = 0; md_start_ex = 0; dmem_req = 0; dmem_ready = 0; clr_stats = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  initial begin
    int nbusy;
    int lwait;
    reset_n = 0;
    idle();
    repeat (3) nxt();
    smp();
    chk("rst_md_busy", md_busy, 0);
    chk("rst_md_done", md_done, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_count", stall_count, 0);
    chk("rst_stall_if", stall_if, 0);
    nxt(); reset_n = 1;
    nxt();

    // forwarding priority
    wreg_mem = 3; regwrite_mem = 1; wreg_wb = 3; regwrite_wb = 1; rs_ex = 3;
    smp(); chk("t1_fwd_mem", fwd_a_ex, 2'b10);
    nxt(); rs_ex = 0; smp(); chk("t1_fwd_r0", fwd_a_ex, 2'b00);
    nxt(); regwrite_mem = 0; rt_ex = 3; smp(); chk("t1_fwd_wb", fwd_b_ex, 2'b01);
    nxt(); idle();

    // load-use, one cycle
    memtoreg_ex = 1; wreg_ex = 5; rt_id = 5;
    smp(); chk("t2_lw", {stall_if, stall_id, flush_ex, stall_ex}, 4'b1110);
    nxt(); idle(); smp(); chk("t2_lw_gone", {stall_if, flush_ex}, 2'b00);

    // mul/div busy window
    nxt(); md_start_ex = 1; smp(); chk("t3_start_nostall", {md_busy, stall_if}, 2'b00);
    for (int i = 1; i <= 3; i++) begin
      nxt(); idle(); smp();
      chk("t3_busy", {md_busy, flush_mem, md_done}, {1'b1, 1'b1, (i == 3)});
    end
    nxt(); smp(); chk("t3_idle", md_busy, 0);

    // mul/div stretched by memory wait
    nxt(); md_start_ex = 1;
    nbusy = 0;
    for (int i = 1; i <= 8; i++) begin
      nxt(); idle();
      if (i == 2 || i == 3) begin dmem_req = 1; dmem_ready = 0; end
      smp();
      if (md_busy) nbusy++;
      if (i == 2) chk("t4_memwait", {stall_mem, flush_wb, flush_mem, stall_if}, 4'b1101);
    end
    chk("t4_busy_len", nbusy, 5);

    // timeout
    nxt(); idle(); clr_stats = 1; nxt(); idle();
    for (int i = 1; i <= MEM_TO; i++) begin
      dmem_req = 1; dmem_ready = 0;
      smp();
      if (i == MEM_TO) chk("t5_not_yet", mem_timeout, 0);
      nxt();
    end
    idle(); smp(); chk("t5_timeout", mem_timeout, 1);
    nxt(); smp(); chk("t5_sticky", mem_timeout, 1);
    nxt(); clr_stats = 1; smp(); chk("t5_clr_cycle", mem_timeout, 1);
    nxt(); idle(); smp(); chk("t5_cleared", {mem_timeout, stall_count}, 5'd0);

    // saturating stall counter, then reset mid mul/div
    for (int i = 0; i < 20; i++) begin
      nxt(); memtoreg_ex = 1; wreg_ex = 7; rs_id = 7;
    end
    nxt(); idle(); smp(); chk("t6_sat", stall_count, 15);
    nxt(); md_start_ex = 1; nxt(); idle(); smp(); chk("t6_busy", md_busy, 1);
    nxt(); reset_n = 0; #1;
    chk("t6_rst", {md_busy, md_done, mem_timeout, stall_count, stall_if, flush_mem}, 0);
    nxt(); reset_n = 1;

    // randomized traffic
    lwait = 0;
    for (int n = 0; n < 4000; n++) begin
      nxt();
      rs_id = REG_AW'($urandom_range(0, 3)); rt_id = REG_AW'($urandom_range(0, 3));
      rs_ex = REG_AW'($urandom_range(0, 3)); rt_ex = REG_AW'($urandom_range(0, 3));
      wreg_ex = REG_AW'($urandom_range(0, 3)); wreg_mem = REG_AW'($urandom_range(0, 3));
      wreg_wb = REG_AW'($urandom_range(0, 3));
      regwrite_ex = 1'($urandom); regwrite_mem = 1'($urandom); regwrite_wb = 1'($urandom);
      memtoreg_ex = ($urandom_range(0, 3) == 0);
      memtoreg_mem = ($urandom_range(0, 3) == 0);
      if (memtoreg_mem) regwrite_mem = 1;
      branch_id = ($urandom_range(0, 2) == 0);
      md_start_ex = ($urandom_range(0, 7) == 0);
      clr_stats = ($urandom_range(0, 99) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      if (lwait == 0 && $urandom_range(0, 199) == 0) lwait = $urandom_range(14, 20);
      if (lwait > 0) begin
        dmem_req = 1; dmem_ready = 0; lwait--;
      end else begin
        dmem_req = ($urandom_range(0, 2) == 0);
        dmem_ready = ($urandom_range(0, 2) != 0);
      end
    end
    nxt(); idle(); reset_n = 1;
    repeat (2) nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
